// File: rtl/xs3_pkg.sv
// Shared definitions for the excess-3 word converter: FSM states and
// the constants that define the legal excess-3 code range.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } xs3_state_e;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'b0011;
    localparam logic [3:0] XS3_MAX    = 4'b1100;

    // True when the 4-bit code is a legal excess-3 digit.
    function automatic logic xs3_legal(input logic [3:0] code);
        return (code >= XS3_MIN) && (code <= XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_conv.sv
// Combinational single-digit excess-3 to BCD converter.
// Illegal codes yield value 0 with valid low.
module xs3_digit_conv
    import xs3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] value,
    output logic       valid
);

    // Decode one excess-3 digit; illegal codes map to zero.
    always_comb begin
        valid = xs3_legal(code);
        if (valid) begin
            value = code - XS3_OFFSET;
        end else begin
            value = 4'd0;
        end
    end

endmodule

// File: rtl/xs3_word_converter_ctrl.sv
// Word-level excess-3 to BCD converter. Accepts a word in IDLE, converts
// one digit per cycle through a single shared digit converter, then holds
// the result in DONE until the consumer takes it.
module xs3_word_converter_ctrl
    import xs3_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   in_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out_bcd,
    output logic [NDIGITS-1:0]     out_err_mask,
    output logic                   out_ok,
    output logic [7:0]             word_count
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    xs3_state_e             state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [4*NDIGITS-1:0]   word_q, word_d;
    logic [4*NDIGITS-1:0]   bcd_q, bcd_d;
    logic [NDIGITS-1:0]     err_q, err_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [3:0]             cur_code_s;
    logic [3:0]             cur_value_s;
    logic                   cur_valid_s;

    // The one shared converter sees the nibble picked by the digit index.
    assign cur_code_s = word_q[{idx_q, 2'b00} +: 4];

    xs3_digit_conv u_digit_conv (
        .code  (cur_code_s),
        .value (cur_value_s),
        .valid (cur_valid_s)
    );

    // Next-state and datapath update for the accept/convert/hold sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    idx_d   = '0;
                    bcd_d   = '0;
                    err_d   = '0;
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                bcd_d[{idx_q, 2'b00} +: 4] = cur_value_s;
                err_d[idx_q]               = ~cur_valid_s;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            bcd_q   <= '0;
            err_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_bcd      = bcd_q;
    assign out_err_mask = err_q;
    assign out_ok       = ~|err_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_xs3_word_converter_ctrl.sv
// Self-checking bench for xs3_word_converter_ctrl: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a transaction-level model (word captured, edges elapsed since capture).
module tb_xs3_word_converter_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [4*N-1:0] in_word = '0;
    logic           in_ready;
    logic           out_valid;
    logic [4*N-1:0] out_bcd;
    logic [N-1:0]   out_err_mask;
    logic           out_ok;
    logic [7:0]     word_count;

    always #5 clk = ~clk;

    xs3_word_converter_ctrl #(.NDIGITS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bcd      (out_bcd),
        .out_err_mask (out_err_mask),
        .out_ok       (out_ok),
        .word_count   (word_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: whether a word is held, edges since it was captured, and what
    // the result registers show while idle.
    bit             m_have = 1'b0;
    int             m_age  = 0;
    logic [4*N-1:0] m_word = '0;
    logic [4*N-1:0] m_shown_bcd = '0;
    logic [N-1:0]   m_shown_err = '0;
    logic [7:0]     m_count = 8'd0;

    function automatic logic [4*N-1:0] ref_bcd(input logic [4*N-1:0] w);
        logic [4*N-1:0] r;
        int c;
        r = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(w[4*i +: 4]);
            r[4*i +: 4] = (c >= 3 && c <= 12) ? 4'(c - 3) : 4'd0;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] ref_err(input logic [4*N-1:0] w);
        logic [N-1:0] r;
        int c;
        for (int i = 0; i < N; i++) begin
            c = int'(w[4*i +: 4]);
            r[i] = !(c >= 3 && c <= 12);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (rst) begin
            m_have = 1'b0;
            m_age = 0;
            m_shown_bcd = '0;
            m_shown_err = '0;
            m_count = 8'd0;
        end else if (!m_have) begin
            if (in_valid) begin
                m_have = 1'b1;
                m_age = 0;
                m_word = in_word;
            end
        end else if (m_age >= N) begin
            if (out_ready) begin
                m_have = 1'b0;
                m_count = m_count + 8'd1;
                m_shown_bcd = ref_bcd(m_word);
                m_shown_err = ref_err(m_word);
            end
        end else begin
            m_age = m_age + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            logic [4*N-1:0] bm, eb;
            logic [N-1:0] em, ee;
            k = m_have ? ((m_age < N) ? m_age : N) : 0;
            bm = '0;
            em = '0;
            for (int i = 0; i < N; i++) begin
                if (i < k) begin
                    bm[4*i +: 4] = 4'hF;
                    em[i] = 1'b1;
                end
            end
            eb = m_have ? (ref_bcd(m_word) & bm) : m_shown_bcd;
            ee = m_have ? (ref_err(m_word) & em) : m_shown_err;
            chk("m_in_ready", 32'(in_ready), 32'(!m_have));
            chk("m_out_valid", 32'(out_valid), 32'(m_have && m_age >= N));
            chk("m_out_bcd", 32'(out_bcd), 32'(eb));
            chk("m_err_mask", 32'(out_err_mask), 32'(ee));
            chk("m_out_ok", 32'(out_ok), 32'(ee == '0));
            chk("m_word_count", 32'(word_count), 32'(m_count));
        end
    end

    // Send one word, check latency and the held result, then hand it off.
    task automatic run_word(input logic [15:0] w, input logic [15:0] eb,
                            input logic [3:0] em, input string tag);
        logic [7:0] c0;
        c0 = word_count;
        in_word = w;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_word = 16'($urandom);
        repeat (N - 1) tick();
        chk({tag, "_lat_early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_bcd"}, 32'(out_bcd), 32'(eb));
        chk({tag, "_mask"}, 32'(out_err_mask), 32'(em));
        chk({tag, "_ok"}, 32'(out_ok), 32'(em == 4'd0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(word_count), 32'(c0 + 8'd1));
    endtask

    initial begin
        logic [15:0] held_bcd;
        logic [3:0]  held_mask;
        logic [7:0]  c0;

        // Pin the reference conversion itself.
        chk("ref_3F43_bcd", 32'(ref_bcd(16'h3F43)), 32'h0010);
        chk("ref_0E21_err", 32'(ref_err(16'h0E21)), 32'hF);

        // Reset and the first cycle after it.
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_ok", 32'(out_ok), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);

        // Reset while the digit index is 2.
        in_word = 16'h3456;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_bcd", 32'(out_bcd), 32'h0);
        chk("midrst_mask", 32'(out_err_mask), 32'h0);
        chk("midrst_ok", 32'(out_ok), 32'd1);
        chk("midrst_count", 32'(word_count), 32'd0);

        // Boundary codes, then count.
        run_word(16'hCCCC, 16'h9999, 4'b0000, "w_CCCC");
        run_word(16'h3333, 16'h0000, 4'b0000, "w_3333");
        chk("count_two", 32'(word_count), 32'd2);
        run_word(16'h3456, 16'h0123, 4'b0000, "w_3456");
        run_word(16'h3F43, 16'h0010, 4'b0100, "w_3F43");
        run_word(16'h0E21, 16'h0000, 4'b1111, "w_0E21");

        // Back-pressure in DONE for six cycles.
        c0 = word_count;
        in_word = 16'h7A5B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (N) tick();
        held_bcd = out_bcd;
        held_mask = out_err_mask;
        chk("stall_bcd_value", 32'(held_bcd), 32'h4728);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_word = 16'hCCCC;
            tick();
            chk("stall_bcd", 32'(out_bcd), 32'(held_bcd));
            chk("stall_mask", 32'(out_err_mask), 32'(held_mask));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_idle", 32'(in_ready), 32'd1);
        chk("stall_release_count", 32'(word_count), 32'(c0 + 8'd1));

        // Second in_valid during CONVERT is ignored.
        in_word = 16'h3456;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_word = 16'hCCCC;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (N - 2) tick();
        chk("ign_valid", 32'(out_valid), 32'd1);
        chk("ign_bcd", 32'(out_bcd), 32'h0123);
        chk("ign_mask", 32'(out_err_mask), 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_word = 16'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
